// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the March BIST initiator driving the 16x8 dual-port RAM.
package ram_bist_pkg;

    localparam int             ADDR_W_DEF  = 4;
    localparam int             DATA_W_DEF  = 8;
    localparam logic [7:0]     PATTERN_DEF = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0W1,
        R1,
        DRAIN,
        DONE
    } state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-check pipeline: remembers each issued read, compares the returned word one
// cycle later, and latches the first mismatch for reporting.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_exp,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              mismatch,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    logic              chk_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] raddr_q;

    assign mismatch = chk_q && (ram_rdata != exp_q);

    // A read issued on the aborting edge must not be checked afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q   <= 1'b0;
            exp_q   <= '0;
            raddr_q <= '0;
        end else if (clear) begin
            chk_q   <= 1'b0;
            exp_q   <= '0;
            raddr_q <= '0;
        end else begin
            chk_q   <= issue && !mismatch;
            exp_q   <= issue_exp;
            raddr_q <= issue_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clear) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch && !fail) begin
            fail      <= 1'b1;
            fail_addr <= raddr_q;
            fail_data <= ram_rdata;
        end
    end

endmodule

// File: rtl/ram_march_bist.sv
// March BIST sequencer: W0 ascending, R0/W1 ascending, R1 descending, then a drain
// cycle for the last check; aborts to DONE on the first mismatch.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(PATTERN_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                DEPTH    = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              clear;
    logic [DATA_W-1:0] issue_exp;
    logic              mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
        end
    end

    // R0W1 reads and writes the same address in one cycle; this relies on the RAM
    // returning the old word for a same-address collision.
    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        clear     = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;
        issue_exp = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n = W0;
                    addr_n  = '0;
                    clear   = 1'b1;
                end
            end
            W0: begin
                ram_we    = 1'b1;
                ram_waddr = addr_q;
                ram_wdata = PATTERN;
                if (addr_q == ADDR_MAX) begin
                    state_n = R0W1;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_q + ADDR_ONE;
                end
            end
            R0W1: begin
                ram_re    = 1'b1;
                ram_raddr = addr_q;
                issue_exp = PATTERN;
                ram_we    = 1'b1;
                ram_waddr = addr_q;
                ram_wdata = ~PATTERN;
                if (mismatch) begin
                    state_n = DONE;
                end else if (addr_q == ADDR_MAX) begin
                    state_n = R1;
                    addr_n  = ADDR_MAX;
                end else begin
                    addr_n = addr_q + ADDR_ONE;
                end
            end
            R1: begin
                ram_re    = 1'b1;
                ram_raddr = addr_q;
                issue_exp = ~PATTERN;
                if (mismatch) begin
                    state_n = DONE;
                end else if (addr_q == '0) begin
                    state_n = DRAIN;
                end else begin
                    addr_n = addr_q - ADDR_ONE;
                end
            end
            DRAIN: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign done = (state_q == DONE);

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .issue      (ram_re),
        .issue_addr (ram_raddr),
        .issue_exp  (issue_exp),
        .ram_rdata  (ram_rdata),
        .mismatch   (mismatch),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data)
    );

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural RAM with injectable faults and a per-cycle
// scoreboard of expected RAM-port activity and status.
module tb_ram_march_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic       fail;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       ram_re;
    logic [3:0] ram_raddr;
    logic [7:0] ram_rdata;

    logic [7:0] mem [16];
    logic [7:0] rd_word;
    int         fault_mode = 0;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0] sb_q [$];

    always #5 clk = ~clk;

    ram_march_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // Fault modes: 1 = bit0 stuck-at-0 at addr 5, 2 = bit0 stuck-at-1 at addr 12,
    // 3 = new-data read on same-address collision.
    always @(posedge clk) begin
        if (ram_re) begin
            rd_word = mem[ram_raddr];
            if (fault_mode == 1 && ram_raddr == 4'd5)  rd_word[0] = 1'b0;
            if (fault_mode == 2 && ram_raddr == 4'd12) rd_word[0] = 1'b1;
            if (fault_mode == 3 && ram_we && ram_waddr == ram_raddr) rd_word = ram_wdata;
            ram_rdata <= rd_word;
        end
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] model_vec(input int k, input int last, input logic efail);
        logic       we, re, d, f;
        logic [3:0] wa, ra;
        logic [7:0] wd;
        we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;
        if (k < last) begin
            if (k < 16) begin
                we = 1'b1; wa = 4'(k); wd = 8'h55;
            end else if (k < 32) begin
                we = 1'b1; wa = 4'(k - 16); wd = 8'hAA;
                re = 1'b1; ra = 4'(k - 16);
            end else if (k < 48) begin
                re = 1'b1; ra = 4'(47 - k);
            end
        end
        d = (k >= last);
        f = d & efail;
        return {d, f, we, wa, wd, re, ra};
    endfunction

    function automatic logic [19:0] observed();
        return {done, fail, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr};
    endfunction

    task automatic kick();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_test(input string tag, input int last, input logic efail,
                            input logic [3:0] eaddr, input logic [7:0] edata, input int inject);
        logic [19:0] exp_vec;
        for (int k = 0; k <= last + 2; k++) sb_q.push_back(model_vec(k, last, efail));
        kick();
        for (int k = 0; k <= last + 2; k++) begin
            if (k > 0) @(negedge clk);
            start = (k == inject);
            exp_vec = sb_q.pop_front();
            check($sformatf("%s cyc%0d", tag, k), 64'(observed()), 64'(exp_vec));
        end
        start = 1'b0;
        check({tag, " fail_addr"}, 64'(fail_addr), 64'(eaddr));
        check({tag, " fail_data"}, 64'(fail_data), 64'(edata));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset status", 64'({done, fail, fail_addr, fail_data}), 64'd0);
        check("reset ports", 64'({ram_we, ram_re}), 64'd0);
        rst = 1'b0;

        fault_mode = 0;
        run_test("pass", 49, 1'b0, 4'd0, 8'h00, -1);

        fault_mode = 1;
        run_test("sa0_a5", 23, 1'b1, 4'd5, 8'h54, -1);

        fault_mode = 0;
        run_test("restart_after_fail", 49, 1'b0, 4'd0, 8'h00, 40);

        fault_mode = 2;
        run_test("sa1_a12", 37, 1'b1, 4'd12, 8'hAB, -1);

        fault_mode = 0;
        kick();
        repeat (23) @(negedge clk);
        check("pre-reset r0w1 a7", 64'(observed()), 64'(model_vec(23, 49, 1'b0)));
        rst = 1'b1;
        #1;
        check("mid reset", 64'({ram_we, ram_re, done, fail}), 64'd0);
        @(negedge clk);
        check("reset hold", 64'(observed()), 64'd0);
        rst = 1'b0;
        run_test("pass_after_reset", 49, 1'b0, 4'd0, 8'h00, -1);

        fault_mode = 3;
        run_test("raw_sem", 18, 1'b1, 4'd0, 8'hAA, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
